// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and requester encoding for the writeback path
package regfile_wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 1 << REG_AW;
  typedef enum logic {REQ_ALU = 1'b0, REQ_LSU = 1'b1} req_id_e;
endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: per-register pending-write flags, set on issue and cleared on writeback
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_idx,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
  // set is applied after clear so a same-edge issue keeps the register pending; r0 never pends
  always_comb begin
    set_mask = set_en ? NUM_REGS'(1) << set_idx : '0;
    clr_mask = clr_en ? NUM_REGS'(1) << clr_idx : '0;
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  end
  // flag register
  always_ff @(posedge clk)
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy = busy_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/LSU writeback arbiter with registered write port and scoreboard
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [REG_AW-1:0]   lsu_rd,
  input  logic [DATA_W-1:0]   lsu_data,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic                RegWrite,
  output logic [REG_AW-1:0]   WriteAddr,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] busy
);
  req_id_e             last_grant_q, last_grant_d, winner;
  logic                reg_write_q, reg_write_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d, acc_rd;
  logic [DATA_W-1:0]   wdata_q, wdata_d, acc_data;
  logic                contended, accept;
  // pick a winner from the valids alone; ready never depends on the write port
  always_comb begin
    contended = alu_valid & lsu_valid;
    winner = contended ? (last_grant_q == REQ_LSU ? REQ_ALU : REQ_LSU)
                       : (alu_valid ? REQ_ALU : REQ_LSU);
    accept = ~rst & (alu_valid | lsu_valid);
    alu_ready = accept & (winner == REQ_ALU);
    lsu_ready = accept & (winner == REQ_LSU);
    acc_rd = winner == REQ_ALU ? alu_rd : lsu_rd;
    acc_data = winner == REQ_ALU ? alu_data : lsu_data;
  end
  // next write-port contents; r0 writes are accepted but discarded, address/data then hold
  always_comb begin
    reg_write_d = accept & (acc_rd != '0);
    waddr_d = reg_write_d ? acc_rd : waddr_q;
    wdata_d = reg_write_d ? acc_data : wdata_q;
    last_grant_d = (accept & contended) ? winner : last_grant_q;
  end
  // write port and round-robin pointer; reset leaves LSU as last winner so ALU wins first
  always_ff @(posedge clk)
    if (rst) begin
      reg_write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_grant_q <= REQ_LSU;
    end else begin
      reg_write_q <= reg_write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  wb_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(issue_valid),
    .set_idx(issue_rd),
    .clr_en(accept),
    .clr_idx(acc_rd),
    .busy(busy)
  );
  assign RegWrite = reg_write_q;
  assign WriteAddr = waddr_q;
  assign WriteData = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the writeback arbiter against a reference model
module tb_regfile_wb_arbiter;
  logic clk = 0;
  logic rst, alu_valid, lsu_valid, issue_valid;
  logic [4:0] alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic alu_ready, lsu_ready, RegWrite;
  logic [4:0] WriteAddr;
  logic [31:0] WriteData, busy;
  int checks = 0, errors = 0;
  int m_last = 1;
  logic [31:0] m_busy = 0;
  logic m_we = 0;
  logic [4:0] m_addr = 0;
  logic [31:0] m_data = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int winner();
    if (rst || (!alu_valid && !lsu_valid)) return -1;
    if (alu_valid && lsu_valid) return (m_last == 1) ? 0 : 1;
    return alu_valid ? 0 : 1;
  endfunction

  function automatic void model_edge();
    int w;
    logic [4:0] rd;
    w = winner();
    m_we = 0;
    if (rst) begin
      m_last = 1;
      m_busy = 0;
      m_addr = 0;
      m_data = 0;
      return;
    end
    if (w >= 0) begin
      rd = (w == 0) ? alu_rd : lsu_rd;
      if (rd != 0) begin
        m_we = 1;
        m_addr = rd;
        m_data = (w == 0) ? alu_data : lsu_data;
      end
      if (alu_valid && lsu_valid) m_last = w;
      m_busy[rd] = 0;
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; alu_data = 0; lsu_data = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    alu_valid = 1; lsu_valid = 1; alu_rd = 9; lsu_rd = 10;
    #1;
    checks++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got alu=%b lsu=%b want 0 0", alu_ready, lsu_ready);
    end
    tick(); tick();
    checks++;
    if (RegWrite !== 1'b0 || WriteAddr !== 5'd0 || WriteData !== 32'd0 || busy !== 32'd0) begin
      errors++; $display("FAIL reset_state got we=%b a=%0d d=%h busy=%h want 0 0 0 0", RegWrite, WriteAddr, WriteData, busy);
    end
    idle();
    rst = 0;
    tick();
  endtask

  task automatic test_alu_single();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL alu_single_ready got alu=%b lsu=%b want 1 0", alu_ready, lsu_ready);
    end
    tick();
    idle();
    checks++;
    if (RegWrite !== 1'b1 || WriteAddr !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_single_write got we=%b a=%0d d=%h want 1 5 deadbeef", RegWrite, WriteAddr, WriteData);
    end
    tick();
    checks++;
    if (RegWrite !== 1'b0 || WriteAddr !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL idle_hold got we=%b a=%0d d=%h want 0 5 deadbeef", RegWrite, WriteAddr, WriteData);
    end
  endtask

  task automatic test_round_robin();
    rst = 1; tick(); rst = 0;
    alu_valid = 1; lsu_valid = 1; alu_rd = 3; lsu_rd = 4;
    alu_data = 32'hA0A0_0003; lsu_data = 32'hB0B0_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (alu_ready !== (i % 2 == 0) || lsu_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL rr_grant%0d got alu=%b lsu=%b want %b %b", i, alu_ready, lsu_ready, i % 2 == 0, i % 2 == 1);
      end
      tick();
      checks++;
      if (RegWrite !== 1'b1 || WriteAddr !== ((i % 2 == 0) ? 5'd3 : 5'd4)
          || WriteData !== ((i % 2 == 0) ? 32'hA0A0_0003 : 32'hB0B0_0004)) begin
        errors++; $display("FAIL rr_write%0d got we=%b a=%0d d=%h want 1 %0d", i, RegWrite, WriteAddr, WriteData, (i % 2 == 0) ? 3 : 4);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_rd_zero();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL rd0_ready got lsu=%b alu=%b want 1 0", lsu_ready, alu_ready);
    end
    tick();
    idle();
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++; $display("FAIL rd0_write got we=%b want 0", RegWrite);
    end
  endtask

  task automatic test_busy();
    issue_valid = 1; issue_rd = 7;
    tick();
    idle();
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++; $display("FAIL busy_set got %h want 00000080", busy);
    end
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    tick();
    idle();
    checks++;
    if (busy !== 32'h0) begin
      errors++; $display("FAIL busy_clear got %h want 00000000", busy);
    end
    issue_valid = 1; issue_rd = 7;
    tick();
    lsu_valid = 1; lsu_rd = 7;
    tick();
    idle();
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++; $display("FAIL busy_set_wins got %h want 00000080", busy);
    end
    issue_valid = 1; issue_rd = 0;
    tick();
    idle();
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++; $display("FAIL busy_r0 got %h want 00000080", busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 1; r < 32; r++) begin
      issue_valid = 1; issue_rd = 5'(r);
      tick();
    end
    idle();
    checks++;
    if (busy !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL busy_all got %h want fffffffe", busy);
    end
    alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2; alu_data = 32'h11; lsu_data = 32'h22;
    tick();
    lsu_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    idle();
    checks++;
    if (RegWrite !== 1'b0 || busy !== 32'h0) begin
      errors++; $display("FAIL reset_mid got we=%b busy=%h want 0 00000000", RegWrite, busy);
    end
    alu_valid = 1; lsu_valid = 1; alu_rd = 8; lsu_rd = 9;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_grant got alu=%b lsu=%b want 1 0", alu_ready, lsu_ready);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      alu_valid = ($urandom_range(0, 9) < 6);
      lsu_valid = ($urandom_range(0, 9) < 6);
      alu_rd = ($urandom_range(0, 3) == 0) ? 5'(0) : 5'($urandom_range(0, 31));
      lsu_rd = 5'($urandom_range(0, 31));
      alu_data = $urandom; lsu_data = $urandom;
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 31));
      #1;
      w = winner();
      checks++;
      if (alu_ready !== (w == 0) || lsu_ready !== (w == 1)) begin
        errors++; $display("FAIL rand_ready n=%0d got alu=%b lsu=%b want %b %b", n, alu_ready, lsu_ready, w == 0, w == 1);
      end
      tick();
      checks++;
      if (RegWrite !== m_we || WriteAddr !== m_addr || WriteData !== m_data) begin
        errors++; $display("FAIL rand_write n=%0d got we=%b a=%0d d=%h want %b %0d %h", n, RegWrite, WriteAddr, WriteData, m_we, m_addr, m_data);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++; $display("FAIL rand_busy n=%0d got %h want %h", n, busy, m_busy);
      end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_round_robin();
    test_rd_zero();
    test_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
